// File: rtl/i2c_slave_pkg.sv
// Shared types and helpers for the I2C slave transmit path.
package i2c_slave_pkg;

    localparam int unsigned MAX_W = 32;
    localparam int unsigned IDX_W = $clog2(MAX_W);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        ACK,
        NEXT
    } tx_state_e;

    // Reverses the low n bits of w; bits at and above n come back as zero.
    function automatic logic [MAX_W-1:0] bit_rev(input logic [MAX_W-1:0] w, input int unsigned n);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            if (i < n) r[IDX_W'(n - 1 - i)] = w[IDX_W'(i)];
        end
        return r;
    endfunction

endpackage

// File: rtl/i2c_tx_fifo.sv
// Word buffer feeding the transmit shifter: push/pop/flush with registered level and not-full.
module i2c_tx_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [DATA_W-1:0]          head,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       not_full
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [LW-1:0]     level_nxt;
    logic              do_push;
    logic              do_pop;

    assign do_push = push && not_full;
    assign do_pop  = pop && (level != '0);
    assign head    = mem[rd_ptr];

    always_comb begin
        level_nxt = level;
        case ({do_push, do_pop})
            2'b10:   level_nxt = level + LW'(1);
            2'b01:   level_nxt = level - LW'(1);
            default: level_nxt = level;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            not_full <= 1'b1;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            not_full <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            level    <= level_nxt;
            not_full <= (level_nxt != LW'(DEPTH));
        end
    end

endmodule

// File: rtl/i2c_slave_tx_burst.sv
// I2C slave burst transmitter: serialises buffered words onto SDA in step with SCL and samples the master's ACK.
module i2c_slave_tx_burst
    import i2c_slave_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          LSB_FIRST   = 1'b0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       scl_i,
    input  logic                       sda_i,
    input  logic                       start_i,
    input  logic                       abort_i,
    input  logic                       flush_i,
    input  logic                       wr_valid_i,
    input  logic [DATA_W-1:0]          wr_data_i,
    output logic                       wr_ready_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       sda_oe_o,
    output logic                       busy_o,
    output logic                       word_done_o,
    output logic                       nack_o,
    output logic                       underflow_o
);

    localparam int unsigned CW = $clog2(DATA_W + 1);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_d;
    logic                   scl_rise;
    logic                   scl_fall;
    logic                   sda_s;

    tx_state_e         state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [CW-1:0]     bitcnt_q, bitcnt_d;
    logic              done_d, nack_d;
    logic              fetch, pop, empty;
    logic [DATA_W-1:0] head, load_word;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            scl_rise <= 1'b0;
            scl_fall <= 1'b0;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
            scl_d    <= scl_sync[SYNC_STAGES-1];
            scl_rise <= scl_sync[SYNC_STAGES-1] & ~scl_d;
            scl_fall <= ~scl_sync[SYNC_STAGES-1] & scl_d;
        end
    end

    assign sda_s = sda_sync[SYNC_STAGES-1];

    i2c_tx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push      (wr_valid_i),
        .push_data (wr_data_i),
        .pop       (pop),
        .flush     (flush_i),
        .head      (head),
        .level     (level_o),
        .not_full  (wr_ready_o)
    );

    // A flush in the fetch cycle makes that fetch see an empty buffer.
    assign empty = (level_o == '0) || flush_i;

    // LSB-first words are stored pre-reversed so the shifter always emits its MSB.
    assign load_word = LSB_FIRST ? DATA_W'(bit_rev(MAX_W'(head), DATA_W)) : head;

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        done_d   = 1'b0;
        nack_d   = 1'b0;
        fetch    = 1'b0;
        if (abort_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        fetch   = 1'b1;
                        state_d = SHIFT;
                    end
                end
                SHIFT: begin
                    if (scl_rise) begin
                        bitcnt_d = bitcnt_q + CW'(1);
                    end else if (scl_fall) begin
                        if (bitcnt_q == CW'(DATA_W)) state_d = ACK;
                        else shreg_d = {shreg_q[DATA_W-2:0], 1'b1};
                    end
                end
                ACK: begin
                    if (scl_rise) begin
                        if (!sda_s) begin
                            done_d  = 1'b1;
                            fetch   = 1'b1;
                            state_d = NEXT;
                        end else begin
                            nack_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
                NEXT: begin
                    if (scl_fall) state_d = SHIFT;
                end
                default: state_d = IDLE;
            endcase
            if (fetch) begin
                shreg_d  = empty ? '1 : load_word;
                bitcnt_d = '0;
            end
        end
    end

    assign pop         = fetch && !empty;
    assign underflow_o = fetch && empty;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            shreg_q     <= '1;
            bitcnt_q    <= '0;
            word_done_o <= 1'b0;
            nack_o      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bitcnt_q    <= bitcnt_d;
            word_done_o <= done_d;
            nack_o      <= nack_d;
        end
    end

    assign sda_oe_o = (state_q == SHIFT) && !shreg_q[DATA_W-1];
    assign busy_o   = (state_q != IDLE);

endmodule

// File: tb/tb_i2c_slave_tx_burst.sv
// Directed bench for the I2C slave burst transmitter: an MSB-first and an LSB-first instance share the bus pins.
module tb_i2c_slave_tx_burst;

    localparam int H = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl = 1'b1;
    logic       sda = 1'b1;
    logic       start0 = 1'b0, start1 = 1'b0;
    logic       abort = 1'b0, flush = 1'b0;
    logic       wv0 = 1'b0, wv1 = 1'b0;
    logic [7:0] wd = '0;

    logic       rdy0, rdy1, oe0, oe1, busy0, busy1;
    logic       done0, done1, nack0, nack1, uf0, uf1;
    logic [2:0] lvl0, lvl1;

    int errors = 0;
    int checks = 0;
    int n_done0 = 0, n_nack0 = 0, n_uf0 = 0;
    int n_done1 = 0, n_uf1 = 0;
    int s_done, s_nack, s_uf;
    logic [7:0] got;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic [2:0] lvl;
        logic       rdy;
    } vec_t;
    vec_t tbl [6];

    always #5 clk = ~clk;

    i2c_slave_tx_burst #(.DATA_W(8), .DEPTH(4), .SYNC_STAGES(2), .LSB_FIRST(1'b0)) u0 (
        .clk_i(clk), .rst_i(rst), .scl_i(scl), .sda_i(sda), .start_i(start0),
        .abort_i(abort), .flush_i(flush), .wr_valid_i(wv0), .wr_data_i(wd),
        .wr_ready_o(rdy0), .level_o(lvl0), .sda_oe_o(oe0), .busy_o(busy0),
        .word_done_o(done0), .nack_o(nack0), .underflow_o(uf0)
    );

    i2c_slave_tx_burst #(.DATA_W(8), .DEPTH(4), .SYNC_STAGES(2), .LSB_FIRST(1'b1)) u1 (
        .clk_i(clk), .rst_i(rst), .scl_i(scl), .sda_i(sda), .start_i(start1),
        .abort_i(abort), .flush_i(flush), .wr_valid_i(wv1), .wr_data_i(wd),
        .wr_ready_o(rdy1), .level_o(lvl1), .sda_oe_o(oe1), .busy_o(busy1),
        .word_done_o(done1), .nack_o(nack1), .underflow_o(uf1)
    );

    always @(negedge clk) begin
        if (done0) n_done0++;
        if (nack0) n_nack0++;
        if (uf0)   n_uf0++;
        if (done1) n_done1++;
        if (uf1)   n_uf1++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input bit sel, input logic [7:0] d);
        if (sel) wv1 = 1'b1; else wv0 = 1'b1;
        wd = d;
        step(1);
        wv0 = 1'b0;
        wv1 = 1'b0;
    endtask

    task automatic pulse_start(input bit sel);
        if (sel) start1 = 1'b1; else start0 = 1'b1;
        step(1);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        step(1);
        abort = 1'b0;
    endtask

    task automatic bit_clk();
        scl = 1'b1;
        step(H);
        scl = 1'b0;
        step(H);
    endtask

    // Master reads 8 bits (line value = ~oe), then drives ACK (sda=0) or NACK.
    task automatic read_byte(input bit sel, input bit ack, output logic [7:0] b);
        b = '0;
        for (int i = 0; i < 8; i++) begin
            scl = 1'b1;
            step(H);
            b = {b[6:0], sel ? ~oe1 : ~oe0};
            scl = 1'b0;
            step(H);
        end
        sda = ~ack;
        bit_clk();
        sda = 1'b1;
    endtask

    initial begin
        tbl[0] = '{1'b1, 8'h11, 3'd1, 1'b1};
        tbl[1] = '{1'b1, 8'h22, 3'd2, 1'b1};
        tbl[2] = '{1'b1, 8'h33, 3'd3, 1'b1};
        tbl[3] = '{1'b1, 8'h44, 3'd4, 1'b0};
        tbl[4] = '{1'b1, 8'h55, 3'd4, 1'b0};
        tbl[5] = '{1'b0, 8'h66, 3'd4, 1'b0};

        step(3);
        rst = 1'b0;
        step(1);
        check("rst_ready", rdy0, 1);
        check("rst_level", lvl0, 0);
        check("rst_oe", oe0, 0);
        check("rst_busy", busy0, 0);
        check("rst_pulses", {done0, nack0, uf0}, 0);
        scl = 1'b0;
        step(6);

        // ACK first word, NACK second
        push(0, 8'hA5);
        push(0, 8'h3C);
        check("t1_level2", lvl0, 2);
        s_done = n_done0; s_nack = n_nack0; s_uf = n_uf0;
        pulse_start(0);
        check("t1_busy", busy0, 1);
        check("t1_level_pop", lvl0, 1);
        read_byte(0, 1'b1, got);
        check("t1_word0", got, 8'hA5);
        read_byte(0, 1'b0, got);
        check("t1_word1", got, 8'h3C);
        check("t1_done", n_done0 - s_done, 1);
        check("t1_nack", n_nack0 - s_nack, 1);
        check("t1_uf", n_uf0 - s_uf, 0);
        check("t1_level_end", lvl0, 0);
        check("t1_idle", busy0, 0);

        // underflow at start and after the ACK
        s_done = n_done0; s_nack = n_nack0; s_uf = n_uf0;
        pulse_start(0);
        check("t3_uf_start", n_uf0 - s_uf, 1);
        read_byte(0, 1'b1, got);
        check("t3_released0", got, 8'hFF);
        check("t3_done", n_done0 - s_done, 1);
        check("t3_uf_ack", n_uf0 - s_uf, 2);
        read_byte(0, 1'b0, got);
        check("t3_released1", got, 8'hFF);
        check("t3_nack", n_nack0 - s_nack, 1);
        check("t3_idle", busy0, 0);

        // fill to full; fifth push ignored
        for (int i = 0; i < 6; i++) begin
            wv0 = tbl[i].v;
            wd  = tbl[i].d;
            step(1);
            wv0 = 1'b0;
            check($sformatf("fill%0d_level", i), lvl0, tbl[i].lvl);
            check($sformatf("fill%0d_ready", i), rdy0, tbl[i].rdy);
        end
        wv0 = 1'b1; wd = 8'h55; start0 = 1'b1;
        step(1);
        wv0 = 1'b0; start0 = 1'b0;
        check("t4_full_push_pop", lvl0, 3);
        check("t4_ready_back", rdy0, 1);
        pulse_abort();
        check("t4_abort_level", lvl0, 3);
        wv0 = 1'b1; wd = 8'h77; start0 = 1'b1;
        step(1);
        wv0 = 1'b0; start0 = 1'b0;
        check("t4_push_pop_level", lvl0, 3);
        s_done = n_done0;
        read_byte(0, 1'b1, got);
        check("t4_w22", got, 8'h22);
        read_byte(0, 1'b1, got);
        check("t4_w33", got, 8'h33);
        read_byte(0, 1'b1, got);
        check("t4_w44", got, 8'h44);
        read_byte(0, 1'b0, got);
        check("t4_w77", got, 8'h77);
        check("t4_done", n_done0 - s_done, 3);
        check("t4_level_end", lvl0, 0);

        // abort mid-word at bit 3
        push(0, 8'h00);
        push(0, 8'h12);
        pulse_start(0);
        repeat (3) bit_clk();
        check("t5_oe_before", oe0, 1);
        s_done = n_done0;
        pulse_abort();
        check("t5_oe_after", oe0, 0);
        check("t5_busy", busy0, 0);
        check("t5_level", lvl0, 1);
        check("t5_no_done", n_done0 - s_done, 0);

        // flush beats a same-cycle push
        flush = 1'b1; wv0 = 1'b1; wd = 8'h55;
        step(1);
        flush = 1'b0; wv0 = 1'b0;
        check("t6_level", lvl0, 0);
        check("t6_ready", rdy0, 1);
        s_uf = n_uf0;
        pulse_start(0);
        check("t6_uf", n_uf0 - s_uf, 1);
        pulse_abort();

        // LSB-first instance, word 0x01
        push(1, 8'h01);
        check("t2_level", lvl1, 1);
        pulse_start(1);
        check("t2_first_oe", oe1, 0);
        check("t2_busy", busy1, 1);
        read_byte(1, 1'b1, got);
        check("t2_line_bits", got, 8'h80);
        check("t2_done", n_done1, 1);
        check("t2_uf_after_ack", n_uf1, 1);
        pulse_abort();
        check("t2_idle", busy1, 0);

        // asynchronous reset mid-word
        push(0, 8'h00);
        pulse_start(0);
        check("t7_oe_driving", oe0, 1);
        #2 rst = 1'b1;
        #1;
        check("t7_oe_async", oe0, 0);
        check("t7_busy_async", busy0, 0);
        check("t7_level_async", lvl0, 0);
        step(1);
        rst = 1'b0;
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
